// File: rtl/romulus_config_pkg.sv
// Shared configuration for the Romulus TBC sequencer: round geometry,
// round-constant width and initial value, FSM state encoding.
package romulus_config_pkg;

    localparam int ROUNDS       = 40;
    localparam int CLKS_PER_RND = 4;
    localparam int KEYSHARES    = 2;
    localparam int CONSTW       = 6;
    localparam int PHASEW       = (CLKS_PER_RND > 1) ? $clog2(CLKS_PER_RND) : 1;

    localparam logic [CONSTW-1:0] RC_INIT = 6'h01;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ROUND   = 2'd1,
        CORRECT = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Skinny round-constant LFSR: shift left, feed back c5 ^ c4 ^ 1.
    function automatic logic [CONSTW-1:0] rc_next(input logic [CONSTW-1:0] c);
        return {c[4:0], c[5] ^ c[4] ^ 1'b1};
    endfunction

endpackage

// File: rtl/skinny_rc_lfsr.sv
// 6-bit Skinny round-constant register with clear/load/step controls.
// Priority: clear over load over step.
module skinny_rc_lfsr
    import romulus_config_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic              step,
    output logic [CONSTW-1:0] rc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rc <= '0;
        end else if (clear) begin
            rc <= '0;
        end else if (load) begin
            rc <= RC_INIT;
        end else if (step) begin
            rc <= rc_next(rc);
        end
    end

endmodule

// File: rtl/romulus_tbc_sequencer.sv
// Control FSM for one Skinny-128-384+ TBC invocation in the masked Romulus
// datapath. Optional `abort` input when ROMULUS_SEQ_ABORT_EN is defined.
module romulus_tbc_sequencer
    import romulus_config_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    incr_cnt,
`ifdef ROMULUS_SEQ_ABORT_EN
    input  logic                    abort,
`endif
    output logic                    busy,
    output logic                    done,
    output logic [CLKS_PER_RND-1:0] ring_en,
    output logic [CONSTW-1:0]       constant,
    output logic                    senc,
    output logic                    sen,
    output logic                    xenc,
    output logic                    xen,
    output logic                    yenc,
    output logic                    yen,
    output logic                    zenc,
    output logic                    zen,
    output logic [1:0]              share_en,
    output logic                    correct_cnt
);

    // Handshake: `start` is a level request sampled only in IDLE; a request
    // seen in any other state is dropped, never queued. `busy` is low exactly
    // when the next `start` will be accepted.
    state_t            state, state_d;
    logic [PHASEW-1:0] phase, phase_d;
    logic [5:0]        rnd, rnd_d;
    logic [0:0]        k, k_d;
    logic              incr_q, incr_d;
    logic              rc_clear, rc_load, rc_step;
    logic              abort_req;
    logic              last_phase, last_rnd, last_k;

`ifdef ROMULUS_SEQ_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign last_phase = (phase == PHASEW'(CLKS_PER_RND - 1));
    assign last_rnd   = (rnd == 6'(ROUNDS - 1));
    assign last_k     = (k == 1'(KEYSHARES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            phase  <= '0;
            rnd    <= '0;
            k      <= '0;
            incr_q <= 1'b0;
        end else begin
            state  <= state_d;
            phase  <= phase_d;
            rnd    <= rnd_d;
            k      <= k_d;
            incr_q <= incr_d;
        end
    end

    always_comb begin
        state_d  = state;
        phase_d  = phase;
        rnd_d    = rnd;
        k_d      = k;
        incr_d   = incr_q;
        rc_clear = 1'b0;
        rc_load  = 1'b0;
        rc_step  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && !abort_req) begin
                    state_d = ROUND;
                    phase_d = '0;
                    rnd_d   = '0;
                    incr_d  = incr_cnt;
                    rc_load = 1'b1;
                end
            end
            ROUND: begin
                if (last_phase) begin
                    phase_d = '0;
                    if (last_rnd) begin
                        state_d  = CORRECT;
                        k_d      = '0;
                        rc_clear = 1'b1;
                    end else begin
                        rnd_d   = rnd + 6'd1;
                        rc_step = 1'b1;
                    end
                end else begin
                    phase_d = phase + PHASEW'(1);
                end
            end
            CORRECT: begin
                if (last_k) begin
                    state_d = DONE;
                end else begin
                    k_d = k + 1'b1;
                end
            end
            DONE: state_d = IDLE;
        endcase
        // Abort overrides whatever progress the case above chose.
        if (abort_req && state != IDLE) begin
            state_d  = IDLE;
            phase_d  = '0;
            rnd_d    = '0;
            k_d      = '0;
            rc_load  = 1'b0;
            rc_step  = 1'b0;
            rc_clear = 1'b1;
        end
    end

    skinny_rc_lfsr u_rc (
        .clk   (clk),
        .rst   (rst),
        .clear (rc_clear),
        .load  (rc_load),
        .step  (rc_step),
        .rc    (constant)
    );

    // Outputs are decoded from registers only, so nothing depends on `start`.
    always_comb begin
        busy        = (state != IDLE);
        done        = 1'b0;
        ring_en     = '0;
        senc        = 1'b0;
        sen         = 1'b0;
        xenc        = 1'b0;
        xen         = 1'b0;
        yenc        = 1'b0;
        yen         = 1'b0;
        zenc        = 1'b0;
        zen         = 1'b0;
        share_en    = '0;
        correct_cnt = 1'b0;
        unique case (state)
            IDLE: ;
            ROUND: begin
                ring_en = CLKS_PER_RND'(1) << phase;
                senc    = 1'b1;
                xenc    = 1'b1;
                yenc    = 1'b1;
                zenc    = 1'b1;
                sen     = 1'b1;
                xen     = 1'b1;
                yen     = last_phase;
                zen     = last_phase;
            end
            CORRECT: begin
                xen         = 1'b1;
                share_en    = 2'b01 << k;
                correct_cnt = incr_q;
                yen         = (k == 1'b0);
                zen         = (k == 1'b0);
            end
            DONE: done = 1'b1;
        endcase
    end

endmodule
